apb_master_arbiter: RTL
=======================

# apb_master_arbiter

APB4 master that shares one APB4 RAM slave between two requesters. Each requester issues single read/write commands over a valid/ready port. The block arbitrates round-robin, sequences the APB SETUP/ACCESS phases, and returns read data and error status. It sits between the bus-side clients and the APB slave RAM.

## Interface
Parameters:
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width
- STRB_WIDTH, 4, PSTRB width (DATA_WIDTH/8)
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables

Ports:
- PCLK  in  1  clock
- PRESET  in  1  reset, asynchronous, active-high
- req_valid  in  2  command valid, one bit per requester
- req_write  in  2  1 = write, per requester
- req_addr  in  2×ADDR_WIDTH  address, per requester
- req_wdata  in  2×DATA_WIDTH  write data, per requester
- req_strb  in  2×STRB_WIDTH  byte strobes, per requester
- req_prot  in  2×3  PPROT value, per requester
- req_ready  out  2  command accepted this cycle (one-hot or zero)
- rsp_valid  out  2  response pulse to the owning requester
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes/aborts)
- rsp_err  out  1  PSLVERR or timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_WIDTH
- PWDATA  out  DATA_WIDTH
- PSTRB  out  STRB_WIDTH
- PPROT  out  3
- PRDATA  in  DATA_WIDTH
- PREADY  in  1
- PSLVERR  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE, any req_valid: grant one requester.
  - req_ready[g]=1 combinationally.
  - Command registered onto the APB outputs at the edge.
  - Next state SETUP.
- SETUP: PSEL=1, PENABLE=0. Next state ACCESS unconditionally.
- ACCESS: PSEL=1, PENABLE=1. Completes on PREADY=1.
  - At the completion edge: capture PRDATA (reads only) and PSLVERR into the response registers.
  - If any req_valid is present in the completion cycle, arbitrate, assert req_ready, load the new command and go straight to SETUP. PSEL stays 1, PENABLE drops.
  - Otherwise go to IDLE with PSEL=0 and PENABLE=0.
- Arbitration: 2-way round-robin on a last_grant register.
  - Only one valid: grant it.
  - Both valid: grant the requester other than last_grant.
  - last_grant resets to 1, so requester 0 wins first.
- Reads: PSTRB is forced to 0 regardless of req_strb (APB4 rule; the slave flags PSLVERR otherwise). PWDATA holds its previous value.
- Writes: PSTRB = req_strb.
- Timeout: a counter increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT, the transfer is aborted: rsp_err=1, rsp_rdata=0, exit as for a normal completion.
  - The counter clears on entry to SETUP.
- Requesters hold req_valid and their command stable until req_ready. The block never deasserts a granted command.
- rsp_rdata/rsp_err hold their value until the next response.

## Timing
- Reset values: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT = 0; rsp_valid=0; rsp_rdata=0; rsp_err=0; req_ready=0; state IDLE; last_grant=1; timeout counter 0.
- Latency with a zero-wait slave (PREADY = PSEL&&PENABLE):
  - cycle 0: req_valid, req_ready.
  - cycle 1: SETUP.
  - cycle 2: ACCESS.
  - cycle 3: rsp_valid pulse for one cycle.
- Back-to-back throughput: one transfer per 2 cycles.
- Each wait state adds one cycle.
- PRESET asserted mid-transfer clears all outputs immediately (asynchronously).
  - The in-flight transfer is dropped; no rsp_valid is issued.
  - Operation resumes normally after release.
- A req_valid that drops before being granted is legal: no grant, no transfer.

## Structure
- Shared package apb_pkg holds:
  - width constants: ADDR/DATA/STRB/PROT widths, shared with the slave;
  - typedef enum apb_state_e {IDLE, SETUP, ACCESS}.
- Sub-module rr_arbiter2: 2-way round-robin grant logic with the last_grant register and an update-enable input.
- FSM, command registers and timeout counter live in apb_master_arbiter.

## Test plan
- Write then read, zero-wait slave:
  - req0 write addr 0x10, wdata 0xDEADBEEF, strb 4'hF → req_ready0 in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid0 in cycle 3 with rsp_err=0.
  - req0 read addr 0x10 → rsp_rdata=0xDEADBEEF, PSTRB=0 observed.
- Contention: req0 and req1 both valid right after reset → req0 served, then req1 back-to-back (PSEL stays high, PENABLE low in its SETUP). Four more simultaneous requests → grants alternate 0,1,0,1.
- Read issued with req_strb=4'hF → PSTRB=0 on the bus, rsp_err=0, data correct.
- TIMEOUT=4, slave model holds PREADY=0 → after 4 ACCESS cycles: rsp_valid, rsp_err=1, rsp_rdata=0, FSM back to IDLE.
- Slave model returns PSLVERR=1 on req1 write → rsp_valid1 with rsp_err=1; rsp_valid0 stays 0.
- PRESET pulsed during ACCESS → all APB outputs 0 without waiting for a clock edge; no rsp_valid. A subsequent req1 read completes in 3 cycles.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: APB widths shared by the master and the RAM slave, plus the master FSM state type.
package apb_pkg;
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = APB_DATA_W / 8;
    localparam int APB_PROT_W = 3;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; last winner is remembered only when en accepts a grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       en,
    output logic [1:0] grant
);
    logic last;
    assign grant = &valid ? (last ? 2'b01 : 2'b10) : valid;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last <= 1'b1;
        else if (en) last <= grant[1];
    end
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin APB4 master for two single-command requesters,
// with SETUP/ACCESS sequencing, back-to-back issue and an optional ACCESS timeout.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_W,
    parameter int DATA_WIDTH = APB_DATA_W,
    parameter int STRB_WIDTH = APB_STRB_W,
    parameter int TIMEOUT    = 16
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic [1:0]                 req_valid,
    input  logic [1:0]                 req_write,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0][STRB_WIDTH-1:0] req_strb,
    input  logic [1:0][APB_PROT_W-1:0] req_prot,
    output logic [1:0]                 req_ready,
    output logic [1:0]                 rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_err,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [ADDR_WIDTH-1:0]      PADDR,
    output logic [DATA_WIDTH-1:0]      PWDATA,
    output logic [STRB_WIDTH-1:0]      PSTRB,
    output logic [APB_PROT_W-1:0]      PPROT,
    input  logic [DATA_WIDTH-1:0]      PRDATA,
    input  logic                       PREADY,
    input  logic                       PSLVERR
);
    localparam int CW = $clog2(TIMEOUT + 2);
    apb_state_e state, state_d;
    logic [CW-1:0] cnt;
    logic [1:0] grant;
    logic owner, g, abort, done, accept, load;
    assign abort  = (TIMEOUT != 0) && state == ACCESS && !PREADY && cnt == CW'(TIMEOUT - 1);
    assign done   = state == ACCESS && (PREADY || abort);
    // Gated by PRESET so req_ready reads 0 while reset is held.
    assign accept = !PRESET && (state == IDLE || done);
    assign load   = accept && |req_valid;
    assign g      = grant[1];
    assign req_ready = accept ? grant : 2'b00;
    assign PSEL    = state != IDLE;
    assign PENABLE = state == ACCESS;
    rr_arbiter2 u_arb (
        .clk  (PCLK),
        .rst  (PRESET),
        .valid(req_valid),
        .en   (load),
        .grant(grant)
    );
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= IDLE;
        else state <= state_d;
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = load ? SETUP : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = done ? (load ? SETUP : IDLE) : ACCESS;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            PPROT     <= '0;
            owner     <= 1'b0;
            cnt       <= '0;
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            cnt <= (state_d == SETUP) ? '0 : (state == ACCESS && !PREADY) ? cnt + 1'b1 : cnt;
            if (load) begin
                PWRITE <= req_write[g];
                PADDR  <= req_addr[g];
                PPROT  <= req_prot[g];
                owner  <= g;
                // Reads drive zero strobes and leave PWDATA untouched.
                PSTRB  <= req_write[g] ? req_strb[g] : '0;
                if (req_write[g]) PWDATA <= req_wdata[g];
            end
            if (done) begin
                rsp_valid <= {owner, !owner};
                rsp_err   <= abort || PSLVERR;
                rsp_rdata <= (abort || PWRITE) ? '0 : PRDATA;
            end
        end
    end
endmodule
